// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator.
// A shared down-counting timebase runs P, P-1 .. 0 and repeats.
// Each channel has a set compare (CMPH) and a clear compare (CMPL).
// The period and compare values are written into shadow registers and
// copied to the active set only at the period boundary (tb==0 with en high).
// Optional feature macro: PWM_DEADTIME_EN
//   When defined, the I/Q outputs get a dead-band of DEAD cycles on their rising edges.
//   When undefined, pwmI follows r and pwmQ follows ~r, each with one cycle of latency.
module pwm_multi_ch #(
  parameter int WIDTH   = 18,
  parameter int NCH     = 4,
  parameter int PRD_RST = 8,
  parameter int DEAD    = 2,
  localparam int ADDR_W = $clog2(2*NCH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  tb,
  output logic              prd_strobe,
  output logic [NCH-1:0]    pwmI,
  output logic [NCH-1:0]    pwmQ
);

  // Out-of-range parameters are caught when the design is elaborated.
  if (NCH < 1 || NCH > 16 || DEAD < 1 || DEAD > 255) begin : g_param_check
    $error("pwm_multi_ch: NCH must be 1..16 and DEAD must be 1..255");
  end

  logic [WIDTH-1:0] prd_sh;
  logic [WIDTH-1:0] prd_act;
  logic [WIDTH-1:0] cmph_sh  [NCH];
  logic [WIDTH-1:0] cmpl_sh  [NCH];
  logic [WIDTH-1:0] cmph_act [NCH];
  logic [WIDTH-1:0] cmpl_act [NCH];
  logic [NCH-1:0]   r;
  logic [NCH-1:0]   r_nxt;
  logic             boundary;

  assign boundary = en && (tb == '0);

  // Timebase counts down and reloads from the period shadow at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb         <= '0;
      prd_act    <= WIDTH'(PRD_RST);
      prd_strobe <= 1'b0;
    end else begin
      prd_strobe <= boundary;
      if (en) begin
        tb <= boundary ? prd_sh : tb - WIDTH'(1);
      end
      if (boundary) begin
        prd_act <= prd_sh;
      end
    end
  end

  // Register writes only ever touch the shadow copies; unknown addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prd_sh <= WIDTH'(PRD_RST);
      for (int n = 0; n < NCH; n++) begin
        cmph_sh[n] <= '0;
        cmpl_sh[n] <= '0;
      end
    end else if (wr_en) begin
      if (wr_addr == '0) begin
        prd_sh <= wr_data;
      end
      for (int n = 0; n < NCH; n++) begin
        if (int'(wr_addr) == 2*n + 1) cmph_sh[n] <= wr_data;
        if (int'(wr_addr) == 2*n + 2) cmpl_sh[n] <= wr_data;
      end
    end
  end

  // Active compares are loaded from the pre-write shadows at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        cmph_act[n] <= '0;
        cmpl_act[n] <= '0;
      end
    end else if (boundary) begin
      for (int n = 0; n < NCH; n++) begin
        cmph_act[n] <= cmph_sh[n];
        cmpl_act[n] <= cmpl_sh[n];
      end
    end
  end

  // Next raw channel state: clear has priority over set, compares beyond the period never hit.
  always_comb begin
    r_nxt = r;
    for (int n = 0; n < NCH; n++) begin
      if (!en) begin
        r_nxt[n] = 1'b0;
      end else if ((tb == cmpl_act[n]) && (cmpl_act[n] <= prd_act)) begin
        r_nxt[n] = 1'b0;
      end else if ((tb == cmph_act[n]) && (cmph_act[n] <= prd_act)) begin
        r_nxt[n] = 1'b1;
      end
    end
  end

  // Raw channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else begin
      r <= r_nxt;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam int CW = $clog2(DEAD + 1);

  logic [CW-1:0] dcnt [NCH];

  // Dead-band: an output rises only once r has held its level for DEAD cycles; falls are immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwmI <= '0;
      pwmQ <= '0;
      for (int n = 0; n < NCH; n++) begin
        dcnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (r_nxt[n] != r[n]) begin
          dcnt[n] <= '0;
        end else if (dcnt[n] != CW'(DEAD)) begin
          dcnt[n] <= dcnt[n] + CW'(1);
        end
        pwmI[n] <= en &&  r[n] && (dcnt[n] == CW'(DEAD));
        pwmQ[n] <= en && !r[n] && (dcnt[n] == CW'(DEAD));
      end
    end
  end
`else
  assign pwmI = r;

  // Complementary output tracks ~r with the same latency and is held low while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwmQ <= '0;
    end else begin
      pwmQ <= en ? ~r_nxt : '0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed scenarios plus randomized traffic for pwm_multi_ch,
// checked every cycle against a behavioural model of the timebase and channels.
module tb_pwm_multi_ch;

  localparam int WIDTH  = 18;
  localparam int NCH    = 4;
  localparam int DEAD   = 2;
  localparam int ADDR_W = $clog2(2*NCH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  tb_val;
  logic              prd_strobe;
  logic [NCH-1:0]    pwmI;
  logic [NCH-1:0]    pwmQ;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_tb, m_prd_sh, m_prd_act;
  logic [WIDTH-1:0] m_ch_sh [NCH], m_cl_sh [NCH], m_ch_act [NCH], m_cl_act [NCH];
  logic [NCH-1:0]   m_r, exp_i, exp_q;
  logic             m_strobe;
  int               m_run [NCH];

  pwm_multi_ch #(.WIDTH(WIDTH), .NCH(NCH), .PRD_RST(8), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tb(tb_val), .prd_strobe(prd_strobe), .pwmI(pwmI), .pwmQ(pwmQ)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic e, input logic w, input logic [ADDR_W-1:0] a,
                                input logic [WIDTH-1:0] d);
    en = e; wr_en = w; wr_addr = a; wr_data = d;
    tick();
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    apply_stimulus(1'b1, 1'b1, a, d);
    wr_en = 1'b0;
  endtask

  task automatic wait_tb(input logic [WIDTH-1:0] v);
    int n = 0;
    while (tb_val != v && n < 64) begin
      tick();
      n++;
    end
    if (tb_val != v) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_tb timeout got %0d expected %0d", tb_val, v);
    end
  endtask

  // One clock of the model: outputs follow from the spec rules applied to the pre-edge state.
  task automatic model_step();
    logic [NCH-1:0] r_new;
    logic           bnd;
    if (rst) begin
      m_tb = '0; m_prd_sh = 8; m_prd_act = 8; m_r = '0; exp_i = '0; exp_q = '0; m_strobe = 0;
      for (int n = 0; n < NCH; n++) begin
        m_ch_sh[n] = '0; m_cl_sh[n] = '0; m_ch_act[n] = '0; m_cl_act[n] = '0; m_run[n] = 0;
      end
      return;
    end
    bnd = en && (m_tb == 0);
    for (int n = 0; n < NCH; n++) begin
      if (!en)                      r_new[n] = 1'b0;
      else if (m_tb == m_cl_act[n]) r_new[n] = 1'b0;
      else if (m_tb == m_ch_act[n]) r_new[n] = 1'b1;
      else                          r_new[n] = m_r[n];
    end
`ifdef PWM_DEADTIME_EN
    for (int n = 0; n < NCH; n++) begin
      exp_i[n] = en &&  m_r[n] && (m_run[n] >= DEAD);
      exp_q[n] = en && !m_r[n] && (m_run[n] >= DEAD);
      m_run[n] = (r_new[n] != m_r[n]) ? 0 : ((m_run[n] < 1000) ? m_run[n] + 1 : m_run[n]);
    end
`else
    exp_i = r_new;
    exp_q = en ? ~r_new : '0;
`endif
    m_r = r_new;
    m_strobe = bnd;
    if (en) m_tb = bnd ? m_prd_sh : m_tb - 1;
    if (bnd) begin
      m_prd_act = m_prd_sh;
      for (int n = 0; n < NCH; n++) begin
        m_ch_act[n] = m_ch_sh[n];
        m_cl_act[n] = m_cl_sh[n];
      end
    end
    if (wr_en) begin
      if (wr_addr == 0) m_prd_sh = wr_data;
      for (int n = 0; n < NCH; n++) begin
        if (int'(wr_addr) == 2*n + 1) m_ch_sh[n] = wr_data;
        if (int'(wr_addr) == 2*n + 2) m_cl_sh[n] = wr_data;
      end
    end
  endtask

  // Compare process: advance the model on every edge and check all outputs just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check_output("tb",         32'(tb_val),     32'(m_tb));
      check_output("prd_strobe", 32'(prd_strobe), 32'(m_strobe));
      check_output("pwmI",       32'(pwmI),       32'(exp_i));
      check_output("pwmQ",       32'(pwmQ),       32'(exp_q));
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int hi0;
    int hi1;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    check_output("rst_tb",     32'(tb_val),     0);
    check_output("rst_strobe", 32'(prd_strobe), 0);
    check_output("rst_pwmI",   32'(pwmI),       0);
    check_output("rst_pwmQ",   32'(pwmQ),       0);

    // Default period: first cycle after reset is a boundary, then 8..0
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t1_first_tb",     32'(tb_val),     8);
    check_output("t1_first_strobe", 32'(prd_strobe), 1);
    check_output("t1_model_tb",     32'(m_tb),       8);
    repeat (8) tick();
    check_output("t1_end_tb",     32'(tb_val),     0);
    check_output("t1_end_strobe", 32'(prd_strobe), 0);
    tick();
    check_output("t1_wrap_tb",     32'(tb_val),     8);
    check_output("t1_wrap_strobe", 32'(prd_strobe), 1);
    check_output("t1_pwmI_low",    32'(pwmI),       0);
    check_output("t1_pwmQ_high",   32'(pwmQ),       32'hF);

    // CMPH0=6, CMPL0=2: no effect before the boundary, then high while tb=5..2
    write_reg(1, 6);
    write_reg(2, 2);
    for (int i = 0; i < 7; i++) begin
      check_output("t2_before_boundary", 32'(pwmI[0]), 0);
      tick();
    end
    hi0 = 0;
    for (int i = 0; i < 9; i++) begin
      hi0 += int'(pwmI[0]);
`ifndef PWM_DEADTIME_EN
      check_output("t2_window", 32'(pwmI[0]), 32'((8 - i) >= 2 && (8 - i) <= 5));
`endif
      tick();
    end
`ifdef PWM_DEADTIME_EN
    check_output("t2_high_count", 32'(hi0), 2);
`else
    check_output("t2_high_count", 32'(hi0), 4);
`endif

    // PRD=3 written mid-period at tb=5
    wait_tb(5);
    write_reg(0, 3);
    wait_tb(0);
    tick();
    check_output("t3_new_prd_tb",     32'(tb_val),     3);
    check_output("t3_new_prd_strobe", 32'(prd_strobe), 1);
    repeat (3) tick();
    check_output("t3_end_tb", 32'(tb_val), 0);
    tick();
    check_output("t3_repeat_tb",     32'(tb_val),     3);
    check_output("t3_repeat_strobe", 32'(prd_strobe), 1);

    // PRD=4 written in the boundary cycle: old period once more, then 4
    wait_tb(0);
    write_reg(0, 4);
    check_output("t4_old_prd_tb", 32'(tb_val), 3);
    repeat (3) tick();
    tick();
    check_output("t4_new_prd_tb",     32'(tb_val),     4);
    check_output("t4_new_prd_strobe", 32'(prd_strobe), 1);

    // Equal compares give 0% duty; a set-only channel latches high and out-of-range compares hold
    write_reg(0, 8);
    write_reg(1, 3);
    write_reg(2, 3);
    write_reg(3, 5);
    write_reg(4, 20);
    wait_tb(0); tick();
    wait_tb(0); tick();
    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 9; i++) begin
      hi0 += int'(pwmI[0]);
      hi1 += int'(pwmI[1]);
      tick();
    end
    check_output("t5_equal_cmp_count", 32'(hi0), 0);
    check_output("t5_latched_count",   32'(hi1), 9);
    write_reg(3, 20);
    wait_tb(0); tick();
    hi1 = 0;
    for (int i = 0; i < 9; i++) begin
      hi1 += int'(pwmI[1]);
      tick();
    end
    check_output("t5_hold_count", 32'(hi1), 9);

    // en low at tb=4 for 5 cycles
    wait_tb(4);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, '0, '0);
      check_output("t6_tb_frozen", 32'(tb_val),     4);
      check_output("t6_pwmI_off",  32'(pwmI),       0);
      check_output("t6_pwmQ_off",  32'(pwmQ),       0);
      check_output("t6_no_strobe", 32'(prd_strobe), 0);
    end
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t6_resume_tb", 32'(tb_val), 3);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      apply_stimulus($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0,
                     ADDR_W'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
